// File: rtl/mem_port_arbiter_if.sv
// Bus bundle between the fetch / load-store requesters, the arbiter and memory.
// The slave modport is the arbiter's view; master is the environment's view.
interface mem_port_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic              if_ack;
  logic [DATA_W-1:0] if_rdata;
  logic              d_req;
  logic              d_we;
  logic [ADDR_W-1:0] d_addr;
  logic [DATA_W-1:0] d_wdata;
  logic              d_ack;
  logic [DATA_W-1:0] d_rdata;
  logic              err;
  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_ready;
  logic [DATA_W-1:0] mem_rdata;
  logic              busy;

  modport slave (
    input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_ready, mem_rdata,
    output if_ack, if_rdata, d_ack, d_rdata, err, mem_req, mem_we, mem_addr, mem_wdata, busy
  );
  modport master (
    output if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_ready, mem_rdata,
    input  if_ack, if_rdata, d_ack, d_rdata, err, mem_req, mem_we, mem_addr, mem_wdata, busy
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between instruction fetch and load/store, D-priority with IF anti-starvation.
// Define MEM_ARB_TIMEOUT_EN to abort a grant (ack+err) after TIMEOUT_CYC cycles without mem_ready.
module mem_port_arbiter #(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int STARVE_MAX  = 4,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic              CLK,
  input  logic              RST_X,
  mem_port_arbiter_if.slave bus
);
  localparam int SW = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
  localparam logic [SW-1:0] SMAX = SW'(STARVE_MAX);

  typedef enum logic [1:0] {IDLE, GNT_IF, GNT_D, DONE} state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              we_q, we_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [SW-1:0]     streak_q, streak_d;
  logic              mem_req_q, mem_req_d;
  logic              if_ack_q, if_ack_d;
  logic              d_ack_q, d_ack_d;
  logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
  logic [DATA_W-1:0] d_rdata_q, d_rdata_d;
`ifdef MEM_ARB_TIMEOUT_EN
  localparam int CW = (TIMEOUT_CYC > 255) ? $clog2(TIMEOUT_CYC + 1) : 8;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          err_q, err_d;
`endif

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    we_d       = we_q;
    wdata_d    = wdata_q;
    streak_d   = streak_q;
    mem_req_d  = 1'b0;
    if_ack_d   = 1'b0;
    d_ack_d    = 1'b0;
    if_rdata_d = if_rdata_q;
    d_rdata_d  = d_rdata_q;
`ifdef MEM_ARB_TIMEOUT_EN
    cnt_d      = cnt_q;
    err_d      = 1'b0;
`endif
    // The streak only counts D grants made while IF is actually waiting.
    if (!bus.if_req) streak_d = '0;
    case (state_q)
      IDLE: begin
        if (bus.d_req && !(bus.if_req && streak_q == SMAX)) begin
          state_d   = GNT_D;
          addr_d    = bus.d_addr;
          we_d      = bus.d_we;
          wdata_d   = bus.d_wdata;
          mem_req_d = 1'b1;
          if (bus.if_req && streak_q != SMAX) streak_d = streak_q + 1'b1;
        end else if (bus.if_req) begin
          state_d   = GNT_IF;
          addr_d    = bus.if_addr;
          we_d      = 1'b0;
          wdata_d   = '0;
          mem_req_d = 1'b1;
          streak_d  = '0;
        end
`ifdef MEM_ARB_TIMEOUT_EN
        cnt_d = '0;
`endif
      end
      GNT_IF, GNT_D: begin
        if (bus.mem_ready) begin
          state_d = DONE;
          if (state_q == GNT_IF) begin
            if_ack_d   = 1'b1;
            if_rdata_d = bus.mem_rdata;
          end else begin
            d_ack_d = 1'b1;
            if (!we_q) d_rdata_d = bus.mem_rdata;
          end
`ifdef MEM_ARB_TIMEOUT_EN
        end else if (cnt_q == CW'(TIMEOUT_CYC - 1)) begin
          // Abort: complete with err, read data left untouched.
          state_d  = DONE;
          err_d    = 1'b1;
          if_ack_d = (state_q == GNT_IF);
          d_ack_d  = (state_q == GNT_D);
        end else begin
          cnt_d     = cnt_q + 1'b1;
          mem_req_d = 1'b1;
        end
`else
        end else begin
          mem_req_d = 1'b1;
        end
`endif
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_X) begin
    if (!RST_X) begin
      state_q    <= IDLE;
      addr_q     <= '0;
      we_q       <= 1'b0;
      wdata_q    <= '0;
      streak_q   <= '0;
      mem_req_q  <= 1'b0;
      if_ack_q   <= 1'b0;
      d_ack_q    <= 1'b0;
      if_rdata_q <= '0;
      d_rdata_q  <= '0;
`ifdef MEM_ARB_TIMEOUT_EN
      cnt_q      <= '0;
      err_q      <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      we_q       <= we_d;
      wdata_q    <= wdata_d;
      streak_q   <= streak_d;
      mem_req_q  <= mem_req_d;
      if_ack_q   <= if_ack_d;
      d_ack_q    <= d_ack_d;
      if_rdata_q <= if_rdata_d;
      d_rdata_q  <= d_rdata_d;
`ifdef MEM_ARB_TIMEOUT_EN
      cnt_q      <= cnt_d;
      err_q      <= err_d;
`endif
    end
  end

  assign bus.mem_req   = mem_req_q;
  assign bus.mem_we    = we_q;
  assign bus.mem_addr  = addr_q;
  assign bus.mem_wdata = wdata_q;
  assign bus.if_ack    = if_ack_q;
  assign bus.d_ack     = d_ack_q;
  assign bus.if_rdata  = if_rdata_q;
  assign bus.d_rdata   = d_rdata_q;
  assign bus.busy      = (state_q != IDLE);
`ifdef MEM_ARB_TIMEOUT_EN
  assign bus.err       = err_q;
`else
  assign bus.err       = 1'b0;
`endif
endmodule
